// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory arbiter between the CPU M stage
// and an external master.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } arb_owner_e;

  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_DATA_W       = 32;
  localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU-side, external-master-side and dmem-side signals around the arbiter.
// The arbiter uses the slave view; the surrounding wrapper uses the master view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_wren;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_grant;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  ext_req, ext_wren, ext_addr, ext_wdata,
    output ext_grant, ext_rvalid, ext_rdata,
    output address_dmem, data, wren,
    input  q_dmem
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output ext_req, ext_wren, ext_addr, ext_wdata,
    input  ext_grant, ext_rvalid, ext_rdata,
    input  address_dmem, data, wren,
    output q_dmem
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive external denials; hit_o flags the denial that reaches the limit,
// and the count restarts from zero on that same edge.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clear_i,
  output logic hit_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign hit_o = inc_i && !clear_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || hit_o) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_TOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has priority, the external master gets one forced
// cycle after STARVE_LIMIT consecutive denials.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input logic            clock,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_e        state_q;
  arb_owner_e        owner;
  logic              starve_inc;
  logic              starve_hit;
  logic              ext_rvalid_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              wren_mux;

  // Ext wins when it is due a forced cycle, or when the CPU is not asking.
  always_comb begin
    owner = OWN_CPU;
    if (bus.ext_req && ((state_q == ARB_FORCE) || !bus.cpu_req)) begin
      owner = OWN_EXT;
    end
  end

  assign bus.ext_grant = bus.ext_req && (owner == OWN_EXT);
  assign bus.cpu_stall = bus.cpu_req && (owner == OWN_EXT);
  assign bus.cpu_rdata = bus.q_dmem;

  always_comb begin
    addr_mux = bus.cpu_addr;
    data_mux = bus.cpu_wdata;
    wren_mux = bus.cpu_req && bus.cpu_wren;
    if (owner == OWN_EXT) begin
      addr_mux = bus.ext_addr;
      data_mux = bus.ext_wdata;
      wren_mux = bus.ext_req && bus.ext_wren;
    end
  end

  assign bus.address_dmem = addr_mux;
  assign bus.data         = data_mux;
  assign bus.wren         = wren_mux;

  assign starve_inc = (state_q == ARB_NORMAL) && bus.ext_req && bus.cpu_req;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (starve_inc),
    .clear_i (!starve_inc),
    .hit_o   (starve_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_NORMAL;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      case (state_q)
        ARB_NORMAL: if (starve_hit) state_q <= ARB_FORCE;
        ARB_FORCE:  state_q <= ARB_NORMAL;
        default:    state_q <= ARB_NORMAL;
      endcase
      ext_rvalid_q <= bus.ext_grant && !bus.ext_wren;
      if (bus.ext_grant && !bus.ext_wren) begin
        ext_rdata_q <= bus.q_dmem;
      end
    end
  end

  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// denial-counting reference model and a shadow memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Environment memory, with a bench-side preload port
  logic [DW-1:0] mem [0:255];
  logic          pl_en   = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.wren) mem[bus.address_dmem[7:0]] <= bus.data;
  end
  assign bus.q_dmem = mem[bus.address_dmem[7:0]];

  // Reference model state
  int            denials;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:255];
  bit            e_grant, e_stall;
  logic          o_grant, o_stall, o_wren;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit creq, input bit cwr, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cdata, input bit ereq, input bit ewr,
                       input logic [AW-1:0] eaddr, input logic [DW-1:0] edata);
    bus.cpu_req   = creq;
    bus.cpu_wren  = cwr;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cdata;
    bus.ext_req   = ereq;
    bus.ext_wren  = ewr;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = edata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    bit            force_now, own_ext, x_wren;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    @(negedge clock);
    force_now = (denials >= LIMIT);
    own_ext   = bus.ext_req && (!bus.cpu_req || force_now);
    e_grant   = own_ext;
    e_stall   = bus.cpu_req && own_ext;
    x_addr    = own_ext ? bus.ext_addr  : bus.cpu_addr;
    x_data    = own_ext ? bus.ext_wdata : bus.cpu_wdata;
    x_wren    = own_ext ? bus.ext_wren  : (bus.cpu_req && bus.cpu_wren);
    chk("grant", 64'(bus.ext_grant), 64'(e_grant));
    chk("stall", 64'(bus.cpu_stall), 64'(e_stall));
    chk("wren",  64'(bus.wren), 64'(x_wren));
    chk("addr",  64'(bus.address_dmem), 64'(x_addr));
    chk("data",  64'(bus.data), 64'(x_data));
    chk("rvalid", 64'(bus.ext_rvalid), 64'(m_rvalid));
    if (m_rvalid) chk("rdata", 64'(bus.ext_rdata), 64'(m_rdata));
    if (!pl_en) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(ref_mem[bus.address_dmem[7:0]]));
    o_grant = bus.ext_grant;
    o_stall = bus.cpu_stall;
    o_wren  = bus.wren;
    m_rvalid = own_ext && !bus.ext_wren;
    if (m_rvalid) m_rdata = ref_mem[bus.ext_addr[7:0]];
    if (x_wren) ref_mem[x_addr[7:0]] = x_data;
    if (force_now) denials = 0;
    else if (bus.ext_req && !own_ext) denials++;
    else denials = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rvalid"}, 64'(bus.ext_rvalid), 64'd0);
    chk({tag, "_rdata"},  64'(bus.ext_rdata),  64'd0);
    chk({tag, "_grant"},  64'(bus.ext_grant),  64'd0);
    chk({tag, "_stall"},  64'(bus.cpu_stall),  64'd0);
    chk({tag, "_wren"},   64'(bus.wren),       64'd0);
  endtask

  task automatic contend(input int n);
    drive(1'b1, 1'b0, 32'd1, '0, 1'b1, 1'b0, 32'd2, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  bit            c_req, c_wr, x_req, x_wr;
  logic [AW-1:0] c_addr, x_addr_r;
  logic [DW-1:0] c_data, x_data_r;
  bit            got;

  initial begin
    idle();
    denials  = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    #1;
    reset_checks("reset");
    for (int i = 0; i < 64; i++) begin
      pl_en   = 1'b1;
      pl_addr = 8'(i);
      pl_data = $urandom;
      ref_mem[i] = pl_data;
      @(posedge clock);
      #1;
    end
    pl_en = 1'b0;
    reset = 1'b0;

    // CPU-only store
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_wren", 64'(o_wren), 64'd1);
      chk("t1_stall", 64'(o_stall), 64'd0);
    end

    // External read only
    idle();
    pl_en = 1'b1; pl_addr = 8'h20; pl_data = 32'h1234;
    step();
    pl_en = 1'b0;
    ref_mem[8'h20] = 32'h1234;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
    step();
    chk("t2_grant", 64'(o_grant), 64'd1);
    chk("t2_rvalid", 64'(bus.ext_rvalid), 64'd1);
    chk("t2_rdata", 64'(bus.ext_rdata), 64'h1234);
    idle();
    step();
    chk("t2_rvalid_drop", 64'(bus.ext_rvalid), 64'd0);

    // Continuous contention: force every fifth cycle
    for (int i = 0; i < 10; i++) begin
      contend(1);
      chk("t3_grant", 64'(o_grant), 64'((i % 5) == 4));
      chk("t3_stall", 64'(o_stall), 64'((i % 5) == 4));
    end
    idle();
    step();

    // Same-address store vs external read
    drive(1'b1, 1'b1, 32'h30, 32'h55, 1'b1, 1'b0, 32'h30, '0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = o_grant;
    end
    chk("t4_granted", 64'(got), 64'd1);
    chk("t4_rdata", 64'(bus.ext_rdata), 64'h55);
    idle();
    step();

    // Forced cycle with the external request withdrawn
    contend(4);
    drive(1'b1, 1'b0, 32'h7, '0, 1'b0, 1'b0, '0, '0);
    step();
    chk("t5_stall", 64'(o_stall), 64'd0);
    for (int i = 0; i < 5; i++) begin
      contend(1);
      chk("t5_grant", 64'(o_grant), 64'(i == 4));
    end
    idle();
    step();

    // Reset just after a granted external read, with a partial denial count
    contend(3);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h5, '0);
    step();
    chk("t6_rvalid_pre", 64'(bus.ext_rvalid), 64'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h1, '0, 1'b1, 1'b0, 32'h2, '0);
    #1;
    chk("t6_rvalid", 64'(bus.ext_rvalid), 64'd0);
    chk("t6_rdata", 64'(bus.ext_rdata), 64'd0);
    idle();
    #1;
    chk("t6_wren", 64'(bus.wren), 64'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    denials  = 0;
    m_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      contend(1);
      chk("t6_grant", 64'(o_grant), 64'(i == 4));
    end

    // Random traffic; stalled CPU and pending ext requests are held unchanged
    c_req = 1'b0; x_req = 1'b0;
    e_grant = 1'b0; e_stall = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!e_stall) begin
        c_req  = ($urandom_range(0, 99) < 60);
        c_wr   = $urandom_range(0, 1) == 1;
        c_addr = $urandom_range(0, 15);
        c_data = $urandom;
      end
      if (!(x_req && !e_grant)) begin
        x_req    = ($urandom_range(0, 99) < 50);
        x_wr     = $urandom_range(0, 1) == 1;
        x_addr_r = $urandom_range(0, 15);
        x_data_r = $urandom;
      end
      drive(c_req, c_wr, c_addr, c_data, x_req, x_wr, x_addr_r, x_data_r);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
